// File: rtl/i2c_pkg.sv
// Shared I2C definitions: camera target address, ACK levels, address bytes
// the initiator issues, and the target FSM state encoding.
package i2c_pkg;

    localparam logic [6:0] CAM_DEV_ADDR = 7'h36;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Address bytes as they appear on the wire (7-bit address plus R/W)
    localparam logic [7:0] CR_ADDR_WR = {CAM_DEV_ADDR, 1'b0};
    localparam logic [7:0] CR_ADDR_RD = {CAM_DEV_ADDR, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_ACK_DEV,
        ST_PTR_HI,
        ST_ACK_HI,
        ST_PTR_LO,
        ST_ACK_LO,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_DATA,
        ST_RD_MACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA pads and produces registered single-cycle bit and
// START/STOP events, together with the SDA level aligned to those events.
module i2c_line_sync (
    input  logic clk_50,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_d;
    logic       sda_d;

    // Synchronizers reset to the idle-bus level so release of reset never
    // manufactures a START.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            scl_ff   <= 2'b11;
            sda_ff   <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda      <= 1'b1;
        end else begin
            scl_ff   <= {scl_ff[0], scl_i};
            sda_ff   <= {sda_ff[0], sda_i};
            scl_d    <= scl_ff[1];
            sda_d    <= sda_ff[1];
            scl_rise <= scl_ff[1] & ~scl_d;
            scl_fall <= ~scl_ff[1] & scl_d;
            start    <= scl_ff[1] & scl_d & sda_d & ~sda_ff[1];
            stop     <= scl_ff[1] & scl_d & ~sda_d & sda_ff[1];
            sda      <= sda_ff[1];
        end
    end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with 16-bit register pointer, bridging OV5640-style write/read
// transactions onto a single-cycle strobe register bus.
//
// state      | meaning
// IDLE       | bus free or after STOP, waiting for START
// DEV        | shifting device address + R/W
// ACK_DEV    | driving ACK for our address (read: fetch first byte)
// PTR_HI     | shifting pointer high byte
// ACK_HI     | ACK for pointer high byte
// PTR_LO     | shifting pointer low byte
// ACK_LO     | ACK for pointer low byte
// WR_DATA    | shifting a write data byte
// ACK_WR     | ACK for write data (reg_we issued)
// RD_DATA    | driving read data bits
// RD_MACK    | SDA released, sampling initiator ACK/NACK
// IGNORE     | not addressed or read NACKed, wait for START
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CAM_DEV_ADDR
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic scl_rise, scl_fall, start, stop, sda;

    i2c_line_sync u_sync (
        .clk_50   (clk_50),
        .reset_n  (reset_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda)
    );

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic        full, full_nxt;
    logic [7:0]  rx_sh, rx_sh_nxt;
    logic [7:0]  tx_sh, tx_sh_nxt;
    logic        inc_pend, inc_pend_nxt;
    logic        cap_pend, cap_pend_nxt;
    logic [15:0] addr_nxt;
    logic [7:0]  wdata_nxt;
    logic        we_nxt, re_nxt, oe_nxt, busy_nxt;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd7;
            full      <= 1'b0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            inc_pend  <= 1'b0;
            cap_pend  <= 1'b0;
            reg_addr  <= 16'h0000;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            full      <= full_nxt;
            rx_sh     <= rx_sh_nxt;
            tx_sh     <= tx_sh_nxt;
            inc_pend  <= inc_pend_nxt;
            cap_pend  <= cap_pend_nxt;
            reg_addr  <= addr_nxt;
            reg_wdata <= wdata_nxt;
            reg_we    <= we_nxt;
            reg_re    <= re_nxt;
            sda_oe    <= oe_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        full_nxt     = full;
        rx_sh_nxt    = rx_sh;
        tx_sh_nxt    = tx_sh;
        inc_pend_nxt = 1'b0;
        cap_pend_nxt = reg_re;
        addr_nxt     = reg_addr;
        wdata_nxt    = reg_wdata;
        we_nxt       = 1'b0;
        re_nxt       = 1'b0;
        oe_nxt       = sda_oe;
        busy_nxt     = busy;

        // Post-write increment lands the cycle after reg_we, so the strobe
        // carries the pre-increment address.
        if (inc_pend)
            addr_nxt = reg_addr + 16'd1;
        // Register file answers one cycle after reg_re.
        if (cap_pend)
            tx_sh_nxt = reg_rdata;

        if (start) begin
            state_nxt   = ST_DEV;
            bit_cnt_nxt = 3'd7;
            full_nxt    = 1'b0;
            oe_nxt      = 1'b0;
        end else if (stop) begin
            state_nxt = ST_IDLE;
            full_nxt  = 1'b0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                ST_DEV, ST_PTR_HI, ST_PTR_LO, ST_WR_DATA: begin
                    if (scl_rise && !full) begin
                        rx_sh_nxt = {rx_sh[6:0], sda};
                        if (bit_cnt == 3'd0)
                            full_nxt = 1'b1;
                        else
                            bit_cnt_nxt = bit_cnt - 3'd1;
                    end else if (scl_fall && full) begin
                        full_nxt    = 1'b0;
                        bit_cnt_nxt = 3'd7;
                        case (state)
                            ST_DEV: begin
                                if (rx_sh[7:1] == DEV_ADDR) begin
                                    state_nxt = ST_ACK_DEV;
                                    oe_nxt    = 1'b1;
                                    busy_nxt  = 1'b1;
                                end else begin
                                    state_nxt = ST_IGNORE;
                                    busy_nxt  = 1'b0;
                                end
                            end
                            ST_PTR_HI: begin
                                addr_nxt[15:8] = rx_sh;
                                state_nxt      = ST_ACK_HI;
                                oe_nxt         = 1'b1;
                            end
                            ST_PTR_LO: begin
                                addr_nxt[7:0] = rx_sh;
                                state_nxt     = ST_ACK_LO;
                                oe_nxt        = 1'b1;
                            end
                            ST_WR_DATA: begin
                                we_nxt       = 1'b1;
                                wdata_nxt    = rx_sh;
                                inc_pend_nxt = 1'b1;
                                state_nxt    = ST_ACK_WR;
                                oe_nxt       = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ACK_DEV: begin
                    // rx_sh[0] still holds R/W; nothing shifts during ACK.
                    if (scl_rise && rx_sh[0]) begin
                        re_nxt = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_nxt = 3'd7;
                        if (rx_sh[0]) begin
                            state_nxt = ST_RD_DATA;
                            oe_nxt    = ~tx_sh[7];
                        end else begin
                            state_nxt = ST_PTR_HI;
                            oe_nxt    = 1'b0;
                        end
                    end
                end
                ST_ACK_HI: begin
                    if (scl_fall) begin
                        state_nxt = ST_PTR_LO;
                        oe_nxt    = 1'b0;
                    end
                end
                ST_ACK_LO, ST_ACK_WR: begin
                    if (scl_fall) begin
                        state_nxt = ST_WR_DATA;
                        oe_nxt    = 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            state_nxt = ST_RD_MACK;
                            full_nxt  = 1'b0;
                            oe_nxt    = 1'b0;
                        end else begin
                            tx_sh_nxt   = {tx_sh[6:0], 1'b0};
                            oe_nxt      = ~tx_sh[6];
                            bit_cnt_nxt = bit_cnt - 3'd1;
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (scl_rise) begin
                        if (sda == ACK) begin
                            addr_nxt = reg_addr + 16'd1;
                            re_nxt   = 1'b1;
                            full_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_IGNORE;
                            busy_nxt  = 1'b0;
                        end
                    end else if (scl_fall && full) begin
                        full_nxt    = 1'b0;
                        state_nxt   = ST_RD_DATA;
                        bit_cnt_nxt = 3'd7;
                        oe_nxt      = ~tx_sh[7];
                    end
                end
                default: begin
                    oe_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench: bit-banged I2C initiator, small register file model and
// strobe monitor, with immediate-assertion checks against hand-computed values.
module tb_i2c_reg_target;
    import i2c_pkg::*;

    localparam int Q = 25;

    logic        clk_50  = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl     = 1'b1;
    logic        sda_m   = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] we_addr_q[$];
    logic [7:0]  we_data_q[$];
    logic [15:0] re_addr_q[$];
    logic        overlap = 1'b0;

    always #10 clk_50 = ~clk_50;

    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_target dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    function automatic logic [7:0] rd_model(input logic [15:0] a);
        case (a)
            16'h300A: return 8'h56;
            16'h300B: return 8'h40;
            default:  return 8'h00;
        endcase
    endfunction

    // Register file: data valid only in the cycle after reg_re
    always @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) reg_rdata <= 8'hEE;
        else          reg_rdata <= reg_re ? rd_model(reg_addr) : 8'hEE;
    end

    always @(negedge clk_50) begin
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) re_addr_q.push_back(reg_addr);
        if (reg_we && reg_re) overlap = 1'b1;
    end

    function automatic logic [15:0] we_a(input int i);
        return (i < we_addr_q.size()) ? we_addr_q[i] : 16'hDEAD;
    endfunction
    function automatic logic [7:0] we_d(input int i);
        return (i < we_data_q.size()) ? we_data_q[i] : 8'hDD;
    endfunction
    function automatic logic [15:0] re_a(input int i);
        return (i < re_addr_q.size()) ? re_addr_q[i] : 16'hDEAD;
    endfunction

    task automatic clear_log();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk_50);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_q();
            scl   = 1'b1; wait_q(); wait_q();
            scl   = 1'b0; wait_q();
        end
    endtask

    task automatic wr(input string tag, input logic [7:0] b, input logic exp_ack);
        logic ack;
        send_bits(b, 8);
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        ack   = sda_line; wait_q();
        scl   = 1'b0; wait_q();
        chk(tag, {31'd0, ack}, {31'd0, exp_ack});
    endtask

    task automatic rd(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl   = 1'b1; wait_q();
            b[i]  = sda_line; wait_q();
            scl   = 1'b0; wait_q();
        end
        sda_m = mack; wait_q();
        scl   = 1'b1; wait_q(); wait_q();
        scl   = 1'b0; wait_q();
        sda_m = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;

        repeat (5) @(negedge clk_50);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_we", {31'd0, reg_we}, 32'd0);
        chk("rst_re", {31'd0, reg_re}, 32'd0);
        chk("rst_addr", {16'd0, reg_addr}, 32'h0000);
        chk("rst_wdata", {24'd0, reg_wdata}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_50);

        // Single write 6C 30 08 82 P
        clear_log();
        i2c_start();
        wr("t1_dev_ack", 8'h6C, 1'b0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wr("t1_hi_ack", 8'h30, 1'b0);
        wr("t1_lo_ack", 8'h08, 1'b0);
        wr("t1_data_ack", 8'h82, 1'b0);
        i2c_stop();
        chk("t1_we_count", we_addr_q.size(), 32'd1);
        chk("t1_we_addr", {16'd0, we_a(0)}, 32'h3008);
        chk("t1_we_data", {24'd0, we_d(0)}, 32'h82);
        chk("t1_addr_after", {16'd0, reg_addr}, 32'h3009);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Burst write 6C 50 00 11 22 33 P
        clear_log();
        i2c_start();
        wr("t2_dev_ack", 8'h6C, 1'b0);
        wr("t2_hi_ack", 8'h50, 1'b0);
        wr("t2_lo_ack", 8'h00, 1'b0);
        wr("t2_d0_ack", 8'h11, 1'b0);
        wr("t2_d1_ack", 8'h22, 1'b0);
        wr("t2_d2_ack", 8'h33, 1'b0);
        i2c_stop();
        chk("t2_we_count", we_addr_q.size(), 32'd3);
        chk("t2_we0_addr", {16'd0, we_a(0)}, 32'h5000);
        chk("t2_we0_data", {24'd0, we_d(0)}, 32'h11);
        chk("t2_we1_addr", {16'd0, we_a(1)}, 32'h5001);
        chk("t2_we1_data", {24'd0, we_d(1)}, 32'h22);
        chk("t2_we2_addr", {16'd0, we_a(2)}, 32'h5002);
        chk("t2_we2_data", {24'd0, we_d(2)}, 32'h33);
        chk("t2_addr_after", {16'd0, reg_addr}, 32'h5003);

        // Pointer write, repeated START, read two bytes (ACK then NACK)
        clear_log();
        i2c_start();
        wr("t3_dev_ack", 8'h6C, 1'b0);
        wr("t3_hi_ack", 8'h30, 1'b0);
        wr("t3_lo_ack", 8'h0A, 1'b0);
        i2c_start();
        wr("t3_rdev_ack", 8'h6D, 1'b0);
        rd(1'b0, rb);
        chk("t3_rd0", {24'd0, rb}, 32'h56);
        rd(1'b1, rb);
        chk("t3_rd1", {24'd0, rb}, 32'h40);
        chk("t3_oe_after_nack", {31'd0, sda_oe}, 32'd0);
        chk("t3_busy_after_nack", {31'd0, busy}, 32'd0);
        i2c_stop();
        chk("t3_re_count", re_addr_q.size(), 32'd2);
        chk("t3_re0_addr", {16'd0, re_a(0)}, 32'h300A);
        chk("t3_re1_addr", {16'd0, re_a(1)}, 32'h300B);
        chk("t3_we_count", we_addr_q.size(), 32'd0);
        chk("t3_addr_after", {16'd0, reg_addr}, 32'h300B);

        // Foreign address 0x78 ignored, then a valid transaction after Sr
        clear_log();
        i2c_start();
        wr("t4_foreign_nack", 8'hF0, 1'b1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        wr("t4_ignored_nack", 8'h12, 1'b1);
        chk("t4_no_we", we_addr_q.size(), 32'd0);
        chk("t4_no_re", re_addr_q.size(), 32'd0);
        i2c_start();
        wr("t4_dev_ack", 8'h6C, 1'b0);
        wr("t4_hi_ack", 8'h40, 1'b0);
        wr("t4_lo_ack", 8'h00, 1'b0);
        wr("t4_data_ack", 8'hAB, 1'b0);
        i2c_stop();
        chk("t4_we_count", we_addr_q.size(), 32'd1);
        chk("t4_we_addr", {16'd0, we_a(0)}, 32'h4000);
        chk("t4_we_data", {24'd0, we_d(0)}, 32'hAB);

        // STOP after 4 bits of a data byte
        clear_log();
        i2c_start();
        wr("t5_dev_ack", 8'h6C, 1'b0);
        wr("t5_hi_ack", 8'h12, 1'b0);
        wr("t5_lo_ack", 8'h34, 1'b0);
        send_bits(8'h5A, 4);
        i2c_stop();
        chk("t5_no_we", we_addr_q.size(), 32'd0);
        chk("t5_state_idle", {28'd0, dut.state}, {28'd0, ST_IDLE});
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_addr", {16'd0, reg_addr}, 32'h1234);

        // Reset asserted while the device-address ACK is being driven
        i2c_start();
        send_bits(8'h6C, 8);
        sda_m = 1'b1;
        wait_q();
        chk("t6_ack_driven", {31'd0, sda_oe}, 32'd1);
        @(posedge clk_50);
        #3 reset_n = 1'b0;
        #1 chk("t6_oe_async_drop", {31'd0, sda_oe}, 32'd0);
        chk("t6_busy_reset", {31'd0, busy}, 32'd0);
        @(negedge clk_50);
        reset_n = 1'b1;
        i2c_stop();
        chk("t6_addr_reset", {16'd0, reg_addr}, 32'h0000);

        // Pointer wrap FFFF -> 0000
        clear_log();
        i2c_start();
        wr("t7_dev_ack", 8'h6C, 1'b0);
        wr("t7_hi_ack", 8'hFF, 1'b0);
        wr("t7_lo_ack", 8'hFF, 1'b0);
        wr("t7_d0_ack", 8'hAA, 1'b0);
        wr("t7_d1_ack", 8'hBB, 1'b0);
        i2c_stop();
        chk("t7_we_count", we_addr_q.size(), 32'd2);
        chk("t7_we0_addr", {16'd0, we_a(0)}, 32'hFFFF);
        chk("t7_we0_data", {24'd0, we_d(0)}, 32'hAA);
        chk("t7_we1_addr", {16'd0, we_a(1)}, 32'h0000);
        chk("t7_we1_data", {24'd0, we_d(1)}, 32'hBB);
        chk("t7_addr_after", {16'd0, reg_addr}, 32'h0001);

        chk("we_re_overlap", {31'd0, overlap}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
